// File: rtl/home_alarm_ctrl.sv
// Home alarm controller: arm/exit delay, armed monitoring, entry delay, alarm siren
// and fire override. Every output is a register loaded from the next-state logic.
module home_alarm_ctrl #(
   parameter int EXIT_CYC  = 16,
   parameter int ENTRY_CYC = 8,
   parameter int BUZZ_HALF = 2
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       SFD,
   input  logic       SRD,
   input  logic       SW,
   input  logic       SFA,
   input  logic       arm,
   input  logic       disarm,
   output logic [2:0] state,
   output logic [2:0] cause,
   output logic [7:0] remaining,
   output logic       alarmbuzz,
   output logic       chime,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4,
      S_FIRE     = 3'd5
   } state_t;

   localparam logic [2:0] C_NONE   = 3'd0;
   localparam logic [2:0] C_FRONT  = 3'd1;
   localparam logic [2:0] C_REAR   = 3'd2;
   localparam logic [2:0] C_FIRE   = 3'd3;
   localparam logic [2:0] C_WINDOW = 3'd4;

   state_t     st, st_n;
   logic [2:0] cause_n;
   logic [7:0] rem_n;
   logic       buzz_n, chime_n, fault_n;
   logic [7:0] siren_cnt, siren_cnt_n;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         st        <= S_DISARMED;
         cause     <= C_NONE;
         remaining <= 8'd0;
         alarmbuzz <= 1'b0;
         chime     <= 1'b0;
         fault     <= 1'b0;
         siren_cnt <= 8'd0;
      end else begin
         st        <= st_n;
         cause     <= cause_n;
         remaining <= rem_n;
         alarmbuzz <= buzz_n;
         chime     <= chime_n;
         fault     <= fault_n;
         siren_cnt <= siren_cnt_n;
      end
   end

   assign state = st;

   always_comb begin
      st_n    = st;
      cause_n = cause;
      rem_n   = 8'd0;
      fault_n = 1'b0;

      // Fire dominates every other input, including disarm.
      if (SFA) begin
         st_n    = S_FIRE;
         cause_n = C_FIRE;
      end else begin
         case (st)
            S_DISARMED: begin
               if (!disarm && arm) begin
                  if (SFD || SRD || SW) begin
                     fault_n = 1'b1;
                  end else begin
                     st_n  = S_EXIT;
                     rem_n = 8'(EXIT_CYC);
                  end
               end
            end
            S_EXIT: begin
               if (disarm) begin
                  st_n    = S_DISARMED;
                  cause_n = C_NONE;
               end else if (remaining <= 8'd1) begin
                  st_n = S_ARMED;
               end else begin
                  rem_n = remaining - 8'd1;
               end
            end
            S_ARMED: begin
               if (disarm) begin
                  st_n    = S_DISARMED;
                  cause_n = C_NONE;
               end else if (SRD) begin
                  st_n    = S_ALARM;
                  cause_n = C_REAR;
               end else if (SW) begin
                  st_n    = S_ALARM;
                  cause_n = C_WINDOW;
               end else if (SFD) begin
                  st_n    = S_ENTRY;
                  cause_n = C_FRONT;
                  rem_n   = 8'(ENTRY_CYC);
               end
            end
            S_ENTRY: begin
               if (disarm) begin
                  st_n    = S_DISARMED;
                  cause_n = C_NONE;
               end else if (SRD || SW || remaining <= 8'd1) begin
                  st_n = S_ALARM;
               end else begin
                  rem_n = remaining - 8'd1;
               end
            end
            S_ALARM: begin
               if (disarm) begin
                  st_n    = S_DISARMED;
                  cause_n = C_NONE;
               end
            end
            S_FIRE: begin
               if (disarm) begin
                  st_n    = S_DISARMED;
                  cause_n = C_NONE;
               end
            end
            default: begin
               st_n    = S_DISARMED;
               cause_n = C_NONE;
            end
         endcase
      end
   end

   // siren_cnt counts cycles spent in the current siren half-period.
   always_comb begin
      chime_n     = (st_n == S_EXIT) || (st_n == S_ENTRY);
      buzz_n      = 1'b0;
      siren_cnt_n = 8'd0;
      if (st_n == S_FIRE) begin
         buzz_n = 1'b1;
      end else if (st_n == S_ALARM) begin
         if (st != S_ALARM) begin
            buzz_n      = 1'b1;
            siren_cnt_n = 8'd1;
         end else if (siren_cnt >= 8'(BUZZ_HALF)) begin
            buzz_n      = ~alarmbuzz;
            siren_cnt_n = 8'd1;
         end else begin
            buzz_n      = alarmbuzz;
            siren_cnt_n = siren_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_home_alarm_ctrl.sv
// Directed bench for home_alarm_ctrl with default parameters (16/8/2); expected
// values are hand-computed constants checked with immediate assertions.
module tb_home_alarm_ctrl;

   logic       Clk = 1'b0;
   logic       Rst, SFD, SRD, SW, SFA, arm, disarm;
   logic [2:0] state, cause;
   logic [7:0] remaining;
   logic       alarmbuzz, chime, fault;

   int tests  = 0;
   int failed = 0;

   home_alarm_ctrl dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .SFD       (SFD),
      .SRD       (SRD),
      .SW        (SW),
      .SFA       (SFA),
      .arm       (arm),
      .disarm    (disarm),
      .state     (state),
      .cause     (cause),
      .remaining (remaining),
      .alarmbuzz (alarmbuzz),
      .chime     (chime),
      .fault     (fault)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] e_st, input logic [2:0] e_cause,
                            input logic [7:0] e_rem, input logic e_buzz, input logic e_chime,
                            input logic e_fault);
      check({tag, ".state"}, {5'd0, state}, {5'd0, e_st});
      check({tag, ".cause"}, {5'd0, cause}, {5'd0, e_cause});
      check({tag, ".remaining"}, remaining, e_rem);
      check({tag, ".alarmbuzz"}, {7'd0, alarmbuzz}, {7'd0, e_buzz});
      check({tag, ".chime"}, {7'd0, chime}, {7'd0, e_chime});
      check({tag, ".fault"}, {7'd0, fault}, {7'd0, e_fault});
   endtask

   // Arm from DISARMED with closed sensors and run through the whole exit delay.
   task automatic go_armed(input string tag);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check_all({tag, ".exit16"}, 3'd1, 3'd0, 8'd16, 1'b0, 1'b1, 1'b0);
      repeat (16) step();
      check_all({tag, ".armed"}, 3'd2, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      Rst = 1'b1; SFD = 1'b0; SRD = 1'b0; SW = 1'b0;
      SFA = 1'b1; arm = 1'b1; disarm = 1'b0;
      step();
      check_all("reset", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      Rst = 1'b0; SFA = 1'b0; arm = 1'b0;
      step();
      check_all("idle", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Exit delay counts 16..1, window opening during exit is ignored.
      arm = 1'b1;
      step();
      arm = 1'b0;
      check_all("exit.start", 3'd1, 3'd0, 8'd16, 1'b0, 1'b1, 1'b0);
      for (int i = 15; i >= 1; i--) begin
         SW = (i == 10);
         step();
         check("exit.rem", remaining, 8'(i));
         check("exit.state", {5'd0, state}, 8'd1);
      end
      SW = 1'b0;
      step();
      check_all("exit.done", 3'd2, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Arm while armed is ignored.
      arm = 1'b1;
      step();
      arm = 1'b0;
      check_all("armed.arm_ignored", 3'd2, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Front door -> entry delay -> alarm with siren 1,1,0,0,1,1.
      SFD = 1'b1;
      step();
      SFD = 1'b0;
      check_all("entry.start", 3'd3, 3'd1, 8'd8, 1'b0, 1'b1, 1'b0);
      for (int i = 7; i >= 1; i--) begin
         step();
         check("entry.rem", remaining, 8'(i));
      end
      step();
      check_all("entry.alarm", 3'd4, 3'd1, 8'd0, 1'b1, 1'b0, 1'b0);
      step(); check("siren.1", {7'd0, alarmbuzz}, 8'd1);
      step(); check("siren.2", {7'd0, alarmbuzz}, 8'd0);
      step(); check("siren.3", {7'd0, alarmbuzz}, 8'd0);
      step(); check("siren.4", {7'd0, alarmbuzz}, 8'd1);
      step(); check("siren.5", {7'd0, alarmbuzz}, 8'd1);
      step(); check("siren.6", {7'd0, alarmbuzz}, 8'd0);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      check_all("alarm.disarm", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Rear and window together: rear wins; later front door does not change cause.
      go_armed("arm2");
      SRD = 1'b1; SW = 1'b1;
      step();
      SRD = 1'b0; SW = 1'b0;
      check_all("rear_win", 3'd4, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0);
      SFD = 1'b1;
      step();
      SFD = 1'b0;
      check_all("rear_win.sfd", 3'd4, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0);
      disarm = 1'b1; arm = 1'b1;
      step();
      disarm = 1'b0; arm = 1'b0;
      check_all("rear_win.disarm", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Window alone from ARMED gives cause 4; siren phase restarts at 1.
      go_armed("arm3");
      SW = 1'b1;
      step();
      SW = 1'b0;
      check_all("window", 3'd4, 3'd4, 8'd0, 1'b1, 1'b0, 1'b0);
      disarm = 1'b1;
      step();
      disarm = 1'b0;

      // Arm refused with window open: one-cycle fault pulse.
      SW = 1'b1; arm = 1'b1;
      step();
      arm = 1'b0;
      check_all("refuse", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      step();
      SW = 1'b0;
      check_all("refuse.after", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Fire during entry overrides disarm; fire clears only with SFA=0 and disarm=1.
      go_armed("arm4");
      SFD = 1'b1;
      step();
      SFD = 1'b0;
      repeat (3) step();
      check("entry5.rem", remaining, 8'd5);
      SFA = 1'b1; disarm = 1'b1;
      step();
      check_all("fire", 3'd5, 3'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      step();
      check_all("fire.hold_disarm", 3'd5, 3'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      SFA = 1'b0; disarm = 1'b0;
      step();
      check_all("fire.latched", 3'd5, 3'd3, 8'd0, 1'b1, 1'b0, 1'b0);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      check_all("fire.clear", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Reset mid exit-delay with fire asserted aborts to all-zero.
      arm = 1'b1;
      step();
      arm = 1'b0;
      repeat (6) step();
      check("exit10.rem", remaining, 8'd10);
      Rst = 1'b1; SFA = 1'b1;
      step();
      check_all("rst_mid", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      Rst = 1'b0; SFA = 1'b0;
      arm = 1'b1; disarm = 1'b1;
      step();
      arm = 1'b0; disarm = 1'b0;
      check_all("arm_disarm", 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
